// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory request arbiter:
// FSM state encoding, command encodings, bus widths and a command check.
package mem_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Only the two one-hot encodings are legal commands.
    function automatic logic isOneHot(input logic [1:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin winner select. When both requesters are ready the
// pointer names the one that has priority; otherwise the single ready
// requester wins.
module mem_arb_rr (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_ptr,
    output logic o_valid,
    output logic o_grant
);

    // Pick the winner from the ready lines and the priority pointer.
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = 1'b0;
        if (i_req0 && i_req1) begin
            o_grant = i_ptr;
        end else if (i_req1) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates two command requesters onto one memory_controller port.
// IDLE -> ISSUE -> WAIT -> DONE, all outputs registered.
// Optional WAIT-state abort counter enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_ready,
    input  logic              req1_ready,
    input  logic [1:0]        req0_cmd,
    input  logic [1:0]        req1_cmd,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              ack0,
    output logic              ack1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        mc_cmd,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    output logic              mc_ready,
    input  logic              mc_valid,
    input  logic [DATA_W-1:0] mc_rdata
);

    state_t              r_state;
    state_t              w_nextState;
    logic                r_ptr;
    logic                r_owner;
    logic                r_ack0, r_ack1, r_done0, r_done1, r_err0, r_err1;
    logic                r_mcReady;
    logic [1:0]          r_mcCmd;
    logic [ADDR_W-1:0]   r_mcAddr;
    logic [DATA_W-1:0]   r_mcWdata;
    logic [DATA_W-1:0]   r_rdata0, r_rdata1;
    logic                w_req0, w_req1;
    logic                w_grantValid, w_grant;
    logic [1:0]          w_winCmd;
    logic [ADDR_W-1:0]   w_winAddr;
    logic [DATA_W-1:0]   w_winWdata;
    logic                w_accept, w_reject, w_finish, w_abort;
    logic                w_timeout;

    // A requester whose ack is high this cycle is still showing the command
    // just consumed; masking it stops a rejected command being seen twice.
    assign w_req0 = req0_ready & ~r_ack0;
    assign w_req1 = req1_ready & ~r_ack1;

    mem_arb_rr u_rr (
        .i_req0  (w_req0),
        .i_req1  (w_req1),
        .i_ptr   (r_ptr),
        .o_valid (w_grantValid),
        .o_grant (w_grant)
    );

    assign w_winCmd   = w_grant ? req1_cmd   : req0_cmd;
    assign w_winAddr  = w_grant ? req1_addr  : req0_addr;
    assign w_winWdata = w_grant ? req1_wdata : req0_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_waitCnt;

    assign w_timeout = (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in WAIT; restarts every time WAIT is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if (r_state != WAIT) begin
            r_waitCnt <= '0;
        end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the one-cycle events that drive the registers.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grantValid) begin
                    if (isOneHot(w_winCmd)) begin
                        w_accept    = 1'b1;
                        w_nextState = ISSUE;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            ISSUE: w_nextState = WAIT;
            WAIT: begin
                if (mc_valid) begin
                    w_finish    = 1'b1;
                    w_nextState = DONE;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake pulses; each lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcReady <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
        end else begin
            r_mcReady <= w_accept;
            r_ack0    <= (w_accept | w_reject) & ~w_grant;
            r_ack1    <= (w_accept | w_reject) & w_grant;
            r_err0    <= (w_reject & ~w_grant) | (w_abort & ~r_owner);
            r_err1    <= (w_reject & w_grant) | (w_abort & r_owner);
            r_done0   <= w_finish & ~r_owner;
            r_done1   <= w_finish & r_owner;
        end
    end

    // Command latch toward the memory controller, held from ISSUE through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= 1'b0;
            r_mcCmd   <= '0;
            r_mcAddr  <= '0;
            r_mcWdata <= '0;
        end else if (w_accept) begin
            r_owner   <= w_grant;
            r_mcCmd   <= w_winCmd;
            r_mcAddr  <= w_winAddr;
            r_mcWdata <= w_winWdata;
        end else if (w_finish || w_abort) begin
            r_mcCmd   <= '0;
            r_mcAddr  <= '0;
            r_mcWdata <= '0;
        end
    end

    // Read data returns to the owning requester; writes leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_finish && (r_mcCmd == CMD_READ)) begin
            if (r_owner) begin
                r_rdata1 <= mc_rdata;
            end else begin
                r_rdata0 <= mc_rdata;
            end
        end
    end

    // Priority passes to the other requester after a reject, completion or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_reject) begin
            r_ptr <= ~w_grant;
        end else if ((r_state == DONE) || w_abort) begin
            r_ptr <= ~r_owner;
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign err0     = r_err0;
    assign err1     = r_err1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign mc_cmd   = r_mcCmd;
    assign mc_addr  = r_mcAddr;
    assign mc_wdata = r_mcWdata;
    assign mc_ready = r_mcReady;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: write, read, round-robin,
// command reject, reset during WAIT and (with MEM_ARB_TIMEOUT_EN) timeout.
module tb_mem_request_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_ready = 1'b0, req1_ready = 1'b0;
    logic [1:0]  req0_cmd = '0, req1_cmd = '0;
    logic [24:0] req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_wdata = '0, req1_wdata = '0;
    logic        ack0, ack1, done0, done1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  mc_cmd;
    logic [24:0] mc_addr;
    logic [15:0] mc_wdata;
    logic        mc_ready;
    logic        mc_valid = 1'b0;
    logic [15:0] mc_rdata = '0;

    int checks = 0;
    int failures = 0;

    mem_request_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_cmd   (req0_cmd),
        .req1_cmd   (req1_cmd),
        .req0_addr  (req0_addr),
        .req1_addr  (req1_addr),
        .req0_wdata (req0_wdata),
        .req1_wdata (req1_wdata),
        .ack0       (ack0),
        .ack1       (ack1),
        .done0      (done0),
        .done1      (done1),
        .err0       (err0),
        .err1       (err1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .mc_cmd     (mc_cmd),
        .mc_addr    (mc_addr),
        .mc_wdata   (mc_wdata),
        .mc_ready   (mc_ready),
        .mc_valid   (mc_valid),
        .mc_rdata   (mc_rdata)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release between edges, stop just after the first live edge.
    task automatic applyStimulusReset();
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mc_valid   = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({ack0, ack1, done0, done1, err0, err1, mc_ready} !== 7'b0) begin failures++; $display("[TB] FAIL reset_pulses got=%b exp=0000000", {ack0, ack1, done0, done1, err0, err1, mc_ready}); end
        checks++; if ({mc_cmd, mc_addr, mc_wdata} !== 43'b0) begin failures++; $display("[TB] FAIL reset_mc_bus got=%h exp=0", {mc_cmd, mc_addr, mc_wdata}); end
        checks++; if ({rdata0, rdata1} !== 32'b0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", {rdata0, rdata1}); end
        applyStimulusReset();
    endtask

    task automatic test_write();
        req0_ready = 1'b1; req0_cmd = 2'b10; req0_addr = 25'h0FFFF; req0_wdata = 16'hAAAA;
        tick();
        checks++; if (mc_ready !== 1'b1) begin failures++; $display("[TB] FAIL write_mc_ready got=%b exp=1", mc_ready); end
        checks++; if ({ack0, ack1} !== 2'b10) begin failures++; $display("[TB] FAIL write_ack got=%b exp=10", {ack0, ack1}); end
        checks++; if (mc_cmd !== 2'b10) begin failures++; $display("[TB] FAIL write_mc_cmd got=%b exp=10", mc_cmd); end
        checks++; if (mc_addr !== 25'h0FFFF) begin failures++; $display("[TB] FAIL write_mc_addr got=%h exp=0ffff", mc_addr); end
        checks++; if (mc_wdata !== 16'hAAAA) begin failures++; $display("[TB] FAIL write_mc_wdata got=%h exp=aaaa", mc_wdata); end
        req0_ready = 1'b0;
        tick();
        checks++; if ({mc_ready, ack0, mc_cmd} !== 4'b0010) begin failures++; $display("[TB] FAIL write_wait_hold got=%b exp=0010", {mc_ready, ack0, mc_cmd}); end
        tick();
        tick();
        mc_valid = 1'b1;
        checks++; if (done0 !== 1'b0) begin failures++; $display("[TB] FAIL write_early_done got=%b exp=0", done0); end
        tick();
        mc_valid = 1'b0;
        checks++; if ({done0, done1} !== 2'b10) begin failures++; $display("[TB] FAIL write_done got=%b exp=10", {done0, done1}); end
        checks++; if ({mc_cmd, mc_addr, mc_wdata} !== 43'b0) begin failures++; $display("[TB] FAIL write_mc_cleared got=%h exp=0", {mc_cmd, mc_addr, mc_wdata}); end
        checks++; if (rdata0 !== 16'h0000) begin failures++; $display("[TB] FAIL write_rdata0 got=%h exp=0000", rdata0); end
        tick();
        checks++; if ({done0, mc_ready} !== 2'b00) begin failures++; $display("[TB] FAIL write_after_done got=%b exp=00", {done0, mc_ready}); end
    endtask

    task automatic test_read();
        req1_ready = 1'b1; req1_cmd = 2'b01; req1_addr = 25'h0FFFF;
        tick();
        checks++; if ({mc_ready, ack0, ack1, mc_cmd} !== 5'b10101) begin failures++; $display("[TB] FAIL read1_issue got=%b exp=10101", {mc_ready, ack0, ack1, mc_cmd}); end
        req1_ready = 1'b0;
        tick();
        mc_valid = 1'b1; mc_rdata = 16'hAAAA;
        tick();
        mc_valid = 1'b0; mc_rdata = 16'h5555;
        checks++; if ({done0, done1} !== 2'b01) begin failures++; $display("[TB] FAIL read1_done got=%b exp=01", {done0, done1}); end
        checks++; if (rdata1 !== 16'hAAAA) begin failures++; $display("[TB] FAIL read1_rdata1 got=%h exp=aaaa", rdata1); end
        checks++; if (rdata0 !== 16'h0000) begin failures++; $display("[TB] FAIL read1_rdata0 got=%h exp=0000", rdata0); end
        tick();
        req0_ready = 1'b1; req0_cmd = 2'b01; req0_addr = 25'h00123;
        tick();
        req0_ready = 1'b0;
        tick();
        mc_valid = 1'b1; mc_rdata = 16'h1234;
        tick();
        mc_valid = 1'b0;
        checks++; if (rdata0 !== 16'h1234) begin failures++; $display("[TB] FAIL read0_rdata0 got=%h exp=1234", rdata0); end
        checks++; if (rdata1 !== 16'hAAAA) begin failures++; $display("[TB] FAIL read0_rdata1 got=%h exp=aaaa", rdata1); end
        tick();
        req0_ready = 1'b1; req0_cmd = 2'b10; req0_wdata = 16'hBEEF;
        tick();
        req0_ready = 1'b0;
        tick();
        mc_valid = 1'b1; mc_rdata = 16'hDEAD;
        tick();
        mc_valid = 1'b0;
        checks++; if ({done0, rdata0} !== {1'b1, 16'h1234}) begin failures++; $display("[TB] FAIL write_keeps_rdata0 got=%h exp=11234", {done0, rdata0}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int issueCycle[4];
        int issueOwner[4];
        int nIssues = 0;
        logic sawIssue = 1'b0;
        applyStimulusReset();
        req0_ready = 1'b1; req0_cmd = 2'b01; req0_addr = 25'h00010;
        req1_ready = 1'b1; req1_cmd = 2'b01; req1_addr = 25'h00020;
        for (int cyc = 1; cyc <= 40 && nIssues < 4; cyc++) begin
            tick();
            mc_valid = sawIssue;
            sawIssue = mc_ready;
            if (mc_ready) begin
                issueCycle[nIssues] = cyc;
                issueOwner[nIssues] = ack1 ? 1 : 0;
                nIssues++;
            end
        end
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        checks++; if (nIssues !== 4) begin failures++; $display("[TB] FAIL b2b_issue_count got=%0d exp=4", nIssues); end
        for (int i = 0; i < nIssues; i++) begin
            checks++; if (issueOwner[i] !== (i % 2)) begin failures++; $display("[TB] FAIL b2b_owner%0d got=%0d exp=%0d", i, issueOwner[i], i % 2); end
            if (i > 0) begin
                checks++; if (issueCycle[i] - issueCycle[i-1] !== 4) begin failures++; $display("[TB] FAIL b2b_gap%0d got=%0d exp=4", i, issueCycle[i] - issueCycle[i-1]); end
            end
        end
        mc_valid = sawIssue;
        repeat (3) tick();
        mc_valid = 1'b0;
        tick();
    endtask

    task automatic test_reject();
        applyStimulusReset();
        req0_ready = 1'b1; req0_cmd = 2'b11;
        req1_ready = 1'b1; req1_cmd = 2'b10; req1_addr = 25'h1ABCD; req1_wdata = 16'h0F0F;
        tick();
        checks++; if ({err0, ack0, err1, ack1, mc_ready} !== 5'b11000) begin failures++; $display("[TB] FAIL reject_pulses got=%b exp=11000", {err0, ack0, err1, ack1, mc_ready}); end
        req0_ready = 1'b0;
        tick();
        checks++; if ({mc_ready, ack1, err0, mc_addr} !== {3'b110, 25'h1ABCD}) begin failures++; $display("[TB] FAIL reject_next_grant got=%h exp=%h", {mc_ready, ack1, err0, mc_addr}, {3'b110, 25'h1ABCD}); end
        req1_ready = 1'b0;
        tick();
        mc_valid = 1'b1;
        tick();
        mc_valid = 1'b0;
        tick();
        req1_ready = 1'b1; req1_cmd = 2'b00;
        tick();
        checks++; if ({err1, ack1, mc_ready} !== 3'b110) begin failures++; $display("[TB] FAIL reject_zero_cmd got=%b exp=110", {err1, ack1, mc_ready}); end
        req1_ready = 1'b0;
        tick();
        checks++; if ({err1, ack1, mc_ready} !== 3'b000) begin failures++; $display("[TB] FAIL reject_single_pulse got=%b exp=000", {err1, ack1, mc_ready}); end
    endtask

    task automatic test_reset_in_wait();
        req0_ready = 1'b1; req0_cmd = 2'b10; req0_addr = 25'h00777; req0_wdata = 16'h7777;
        tick();
        req0_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({mc_cmd, mc_addr, mc_wdata, mc_ready} !== 44'b0) begin failures++; $display("[TB] FAIL rstwait_mc_bus got=%h exp=0", {mc_cmd, mc_addr, mc_wdata, mc_ready}); end
        checks++; if ({rdata0, rdata1} !== 32'b0) begin failures++; $display("[TB] FAIL rstwait_rdata got=%h exp=0", {rdata0, rdata1}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mc_valid = 1'b1;
        tick();
        mc_valid = 1'b0;
        checks++; if ({done0, done1, err0, err1, mc_ready} !== 5'b0) begin failures++; $display("[TB] FAIL rstwait_no_done got=%b exp=00000", {done0, done1, err0, err1, mc_ready}); end
        tick();
        checks++; if ({done0, done1} !== 2'b0) begin failures++; $display("[TB] FAIL rstwait_no_done_late got=%b exp=00", {done0, done1}); end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int errAt = 0;
        applyStimulusReset();
        req0_ready = 1'b1; req0_cmd = 2'b01; req0_addr = 25'h00042;
        tick();
        req0_ready = 1'b0;
        for (int i = 1; i <= 12 && errAt == 0; i++) begin
            tick();
            if (err0) errAt = i;
        end
        checks++; if (errAt !== 9) begin failures++; $display("[TB] FAIL timeout_err_cycle got=%0d exp=9", errAt); end
        checks++; if ({done0, mc_cmd} !== 3'b0) begin failures++; $display("[TB] FAIL timeout_cleanup got=%b exp=000", {done0, mc_cmd}); end
        tick();
    endtask
`endif

    initial begin
        $display("[TB] start");
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reject();
        test_reset_in_wait();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
